// File: rtl/alu_arbiter_if.sv
// Request/response/alu-side signal bundle for the two-requester alu arbiter.
// Latency: none, wires only.
// Backpressure: carries valid/ready on both request and response channels.
interface alu_arbiter_if;
    // Request channels, bit i / suffix i = requester i
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [3:0]  req_aluc0;
    logic [3:0]  req_aluc1;

    // Response channels share one result/flags bus
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_flags;

    // Shared alu datapath
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic        alu_overflow;

    // Environment side: requesters plus the alu instance
    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_aluc0, req_aluc1,
        input  req_ready,
        input  rsp_valid, rsp_r, rsp_flags,
        output rsp_ready,
        input  alu_a, alu_b, alu_aluc,
        output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_aluc0, req_aluc1,
        output req_ready,
        output rsp_valid, rsp_r, rsp_flags,
        input  rsp_ready,
        output alu_a, alu_b, alu_aluc,
        input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one 32-bit alu between two requesters; optional grant stats via ALU_ARB_STATS_EN.
// Latency: accept edge -> 1 EXEC cycle -> registered response; 3 cycles per op with zero-wait responses.
// Backpressure: result/flags held in RESP until the owner's rsp_ready; no new request accepted until then.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0,
    parameter int   STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        owner;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_aluc;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_r_q;
    logic [3:0]  rsp_flags_q;

    logic        win_vld;
    logic        win_id;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_aluc;
    logic        carry_en;
    logic        ovf_en;
    logic [3:0]  flags_masked;

    // Winner selection: a lone requester wins outright, a tie goes to the pointer
    always_comb begin
        win_vld = |bus.req_valid;
        win_id  = 1'b0;
        case (bus.req_valid)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = rr_ptr;
            default: win_id = 1'b0;
        endcase
        accept   = (state == IDLE) && win_vld;
        sel_a    = win_id ? bus.req_a1    : bus.req_a0;
        sel_b    = win_id ? bus.req_b1    : bus.req_b0;
        sel_aluc = win_id ? bus.req_aluc1 : bus.req_aluc0;
    end

    // Only the winner sees ready, and only while idle
    always_comb begin
        bus.req_ready = 2'b00;
        if (accept) begin
            bus.req_ready = win_id ? 2'b10 : 2'b01;
        end
    end

    // Drop carry/overflow the current opcode does not define, so stale alu flags never leak out
    always_comb begin
        carry_en = (op_aluc == 4'b0000) || (op_aluc == 4'b0001) ||
                   (op_aluc == 4'b1010) || (op_aluc[3:2] == 2'b11);
        ovf_en   = (op_aluc[3:1] == 3'b001);
        flags_masked = {bus.alu_zero,
                        bus.alu_carry & carry_en,
                        bus.alu_negative,
                        bus.alu_overflow & ovf_en};
    end

    // Control FSM with registered operands, result, flags and response valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= RR_INIT;
            owner       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_aluc     <= '0;
            rsp_valid_q <= 2'b00;
            rsp_r_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_aluc <= sel_aluc;
                        owner   <= win_id;
                        rr_ptr  <= ~win_id;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_r_q     <= bus.alu_r;
                    rsp_flags_q <= flags_masked;
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    // Non-owner rsp_ready is deliberately ignored
                    if (bus.rsp_ready[owner]) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a     = op_a;
    assign bus.alu_b     = op_b;
    assign bus.alu_aluc  = op_aluc;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_flags = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
    localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] cnt0_q;
    logic [STAT_W-1:0] cnt1_q;

    // Saturating per-requester accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (!win_id && !(&cnt0_q)) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (win_id && !(&cnt1_q)) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural alu.
// Latency: checks accept -> EXEC -> RESP timing and 3-cycle throughput.
// Backpressure: exercises stalled responses and ignored non-owner rsp_ready.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    int          checks;
    int          errors;

    alu_arbiter_if bus();

    alu_arbiter #(
        .RR_INIT (1'b0),
        .STAT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu; undefined carry/overflow are driven high as stale junk
    logic [32:0] m_wide;
    logic [31:0] m_r;
    logic        m_c;
    logic        m_v;
    always_comb begin
        m_wide = '0;
        m_r    = bus.alu_a ^ bus.alu_b;
        m_c    = 1'b1;
        m_v    = 1'b1;
        case (bus.alu_aluc)
            4'b0000, 4'b0010: begin
                m_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_r    = m_wide[31:0];
                m_c    = m_wide[32];
                m_v    = (bus.alu_a[31] == bus.alu_b[31]) && (m_r[31] != bus.alu_a[31]);
            end
            4'b0001, 4'b0011: begin
                m_r = bus.alu_a - bus.alu_b;
                m_c = bus.alu_a < bus.alu_b;
                m_v = (bus.alu_a[31] != bus.alu_b[31]) && (m_r[31] != bus.alu_a[31]);
            end
            4'b0100: m_r = bus.alu_a & bus.alu_b;
            4'b1110: begin
                m_wide = {1'b0, bus.alu_b} << bus.alu_a[4:0];
                m_r    = m_wide[31:0];
                m_c    = m_wide[32];
            end
            default: m_r = bus.alu_a ^ bus.alu_b;
        endcase
        bus.alu_r        = m_r;
        bus.alu_zero     = (m_r == 32'h0);
        bus.alu_negative = m_r[31];
        bus.alu_carry    = m_c;
        bus.alu_overflow = m_v;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one request, wait for acceptance and for its response; returns at a negedge in RESP
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bit seen;
        @(posedge clk); #1;
        if (id == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_aluc0 = op;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_aluc1 = op;
        end
        bus.req_valid[id] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL issue_accept: req %0d never accepted, req_ready=%b", id, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid[id]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL issue_rsp: req %0d no response, rsp_valid=%b", id, bus.rsp_valid);
        end
    endtask

    task automatic finish_rsp(input int id);
        bus.rsp_ready[id] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.req_aluc0 = '0; bus.req_aluc1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid: ready=%b rsp_valid=%b expected 00/00", bus.req_ready, bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_r, bus.rsp_flags} !== 36'h0) begin
            errors++;
            $display("FAIL reset_rsp: rsp_r=%h flags=%b expected 0", bus.rsp_r, bus.rsp_flags);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_aluc} !== 68'h0) begin
            errors++;
            $display("FAIL reset_ops: a=%h b=%h aluc=%h expected 0", bus.alu_a, bus.alu_b, bus.alu_aluc);
        end
        checks++;
        if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d expected 0", grant_cnt0, grant_cnt1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n_acc, n_rsp, cyc, last_acc;
        logic [1:0]  exp_own;
        logic [31:0] exp_r;
        n_acc = 0; n_rsp = 0; cyc = 0; last_acc = -1;
        @(posedge clk); #1;
        bus.req_a0 = 32'd10; bus.req_b0 = 32'd1; bus.req_aluc0 = 4'b0000;
        bus.req_a1 = 32'd20; bus.req_b1 = 32'd2; bus.req_aluc1 = 4'b0001;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        while (n_acc < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != 2'b00) begin
                exp_own = (n_acc % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (bus.req_ready !== exp_own) begin
                    errors++;
                    $display("FAIL rr_grant: accept %0d req_ready=%b expected %b", n_acc, bus.req_ready, exp_own);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++;
                        $display("FAIL rr_spacing: gap=%0d expected 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            if (bus.rsp_valid != 2'b00) begin
                exp_own = (n_rsp % 2 == 0) ? 2'b01 : 2'b10;
                exp_r   = (n_rsp % 2 == 0) ? 32'd11 : 32'd18;
                checks++;
                if ({bus.rsp_valid, bus.rsp_r} !== {exp_own, exp_r}) begin
                    errors++;
                    $display("FAIL rr_rsp: rsp_valid=%b r=%0d expected %b/%0d", bus.rsp_valid, bus.rsp_r, exp_own, exp_r);
                end
                n_rsp++;
            end
        end
        checks++;
        if (n_acc != 8) begin
            errors++;
            $display("FAIL rr_timeout: accepts=%0d expected 8", n_acc);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                exp_own = (n_rsp % 2 == 0) ? 2'b01 : 2'b10;
                exp_r   = (n_rsp % 2 == 0) ? 32'd11 : 32'd18;
                checks++;
                if ({bus.rsp_valid, bus.rsp_r} !== {exp_own, exp_r}) begin
                    errors++;
                    $display("FAIL rr_drain: rsp_valid=%b r=%0d expected %b/%0d", bus.rsp_valid, bus.rsp_r, exp_own, exp_r);
                end
                n_rsp++;
            end
        end
        bus.rsp_ready = 2'b00;
        checks++;
        if (n_rsp != 8) begin
            errors++;
            $display("FAIL rr_rsp_count: responses=%0d expected 8", n_rsp);
        end
        checks++;
`ifdef ALU_ARB_STATS_EN
        if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd4) begin
            errors++;
            $display("FAIL rr_counters: cnt0=%0d cnt1=%0d expected 4/4", grant_cnt0, grant_cnt1);
        end
`else
        if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL rr_counters: cnt0=%0d cnt1=%0d expected 0/0", grant_cnt0, grant_cnt1);
        end
`endif
    endtask

    task automatic test_single_add();
        @(posedge clk); #1;
        bus.req_a0 = 32'd5; bus.req_b0 = 32'd7; bus.req_aluc0 = 4'b0010;
        bus.req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL add_ready: req_ready=%b expected 01", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_aluc, bus.rsp_valid} !== {32'd5, 32'd7, 4'b0010, 2'b00}) begin
            errors++;
            $display("FAIL add_exec: a=%h b=%h aluc=%b rsp_valid=%b expected 5/7/0010/00",
                     bus.alu_a, bus.alu_b, bus.alu_aluc, bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_r, bus.rsp_flags} !== {2'b01, 32'd12, 4'b0000}) begin
            errors++;
            $display("FAIL add_rsp: rsp_valid=%b r=%h flags=%b expected 01/0000000c/0000",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_flags);
        end
        finish_rsp(0);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL add_drop: rsp_valid=%b expected 00", bus.rsp_valid);
        end
    endtask

    task automatic test_overflow_flags();
        issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        checks++;
        if ({bus.rsp_valid, bus.rsp_r, bus.rsp_flags} !== {2'b01, 32'h8000_0000, 4'b0011}) begin
            errors++;
            $display("FAIL add_ovf: rsp_valid=%b r=%h flags=%b expected 01/80000000/0011",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_flags);
        end
        finish_rsp(0);
        issue(1, 32'd3, 32'd5, 4'b0001);
        checks++;
        if ({bus.rsp_valid, bus.rsp_r, bus.rsp_flags} !== {2'b10, 32'hFFFF_FFFE, 4'b0110}) begin
            errors++;
            $display("FAIL subu_flags: rsp_valid=%b r=%h flags=%b expected 10/fffffffe/0110",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_flags);
        end
        finish_rsp(1);
    endtask

    task automatic test_shift_flags();
        issue(0, 32'h0000_0001, 32'h8000_0000, 4'b1110);
        checks++;
        if ({bus.rsp_r, bus.rsp_flags} !== {32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL sll_flags: r=%h flags=%b expected 00000000/1100", bus.rsp_r, bus.rsp_flags);
        end
        finish_rsp(0);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100);
        checks++;
        if ({bus.rsp_r, bus.rsp_flags} !== {32'hFFFF_FFFF, 4'b0010}) begin
            errors++;
            $display("FAIL and_flags: r=%h flags=%b expected ffffffff/0010", bus.rsp_r, bus.rsp_flags);
        end
        finish_rsp(1);
    endtask

    task automatic test_stall();
        bit seen;
        issue(0, 32'd100, 32'd23, 4'b0000);
        bus.req_a1 = 32'd9; bus.req_b1 = 32'd4; bus.req_aluc1 = 4'b0001;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_r, bus.rsp_flags} !== {2'b01, 2'b00, 32'd123, 4'b0000}) begin
                errors++;
                $display("FAIL stall_hold: cyc %0d rsp_valid=%b ready=%b r=%0d flags=%b expected 01/00/123/0000",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_r, bus.rsp_flags);
            end
        end
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== {2'b00, 2'b10}) begin
            errors++;
            $display("FAIL stall_next: rsp_valid=%b req_ready=%b expected 00/10", bus.rsp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        checks++;
        if ({seen, bus.rsp_valid, bus.rsp_r} !== {1'b1, 2'b10, 32'd5}) begin
            errors++;
            $display("FAIL stall_follow: seen=%0d rsp_valid=%b r=%0d expected 1/10/5", seen, bus.rsp_valid, bus.rsp_r);
        end
        finish_rsp(1);
    endtask

    task automatic test_reset_in_exec();
        @(posedge clk); #1;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_aluc0 = 4'b0000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_accept: req_ready=%b expected 01", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_exec: rsp_valid=%b req_ready=%b expected 00/00", bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 2'b00) begin
                errors++;
                $display("FAIL rst_norsp: cyc %0d rsp_valid=%b expected 00", i, bus.rsp_valid);
            end
        end
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_ptr: req_ready=%b expected 01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_single_add();
        test_overflow_flags();
        test_shift_flags();
        test_stall();
        test_reset_in_exec();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
